// File: rtl/ntt_frame_scheduler_if.sv
// ntt_frame_scheduler_if: requester beats, core in/out and tagged response signals of the frame scheduler
interface ntt_frame_scheduler_if #(
  parameter int NUM_REQ = 2,
  parameter int BEAT_W = 1792,
  parameter int NUM_STAGES = 9,
  parameter int ID_W = 1
);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ*BEAT_W-1:0] req_data;
  logic [BEAT_W-1:0] core_in_data;
  logic [NUM_STAGES-1:0] core_in_start;
  logic core_out_start;
  logic [BEAT_W-1:0] core_out_data;
  logic rsp_valid;
  logic [ID_W-1:0] rsp_id;
  logic rsp_first;
  logic rsp_last;
  logic [BEAT_W-1:0] rsp_data;
  modport master (
    output req_valid, req_data, core_out_start, core_out_data,
    input req_ready, core_in_data, core_in_start, rsp_valid, rsp_id, rsp_first, rsp_last, rsp_data
  );
  modport slave (
    input req_valid, req_data, core_out_start, core_out_data,
    output req_ready, core_in_data, core_in_start, rsp_valid, rsp_id, rsp_first, rsp_last, rsp_data
  );
endinterface

// File: rtl/ntt_frame_scheduler.sv
// ntt_frame_scheduler: round-robin frame arbiter feeding the NTT core, with a tag FIFO returning requester IDs
module ntt_frame_scheduler #(
  parameter int DATA_WIDTH_PER_INPUT = 28,
  parameter int INPUT_PER_CYCLE = 64,
  parameter int FRAME_BEATS = 16,
  parameter int NUM_STAGES = 9,
  parameter int NUM_REQ = 2,
  parameter int GAP_CYCLES = 0,
  parameter int MAX_OUTSTANDING = 4,
  localparam int BEAT_W = DATA_WIDTH_PER_INPUT * INPUT_PER_CYCLE,
  localparam int ID_W = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
  input  logic clk,
  input  logic rst,
  ntt_frame_scheduler_if.slave bus,
  output logic busy,
  output logic err_underrun,
  output logic err_spurious,
  output logic err_overlap
);
  localparam int BC_W = FRAME_BEATS > 1 ? $clog2(FRAME_BEATS) : 1;
  localparam int PTR_W = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  typedef enum logic [1:0] {IDLE, STREAM, GAP} state_t;
  state_t state, state_nx;
  logic [ID_W-1:0] rr_ptr, grant, pick;
  logic found, push, pop, full, last_beat, rsp_more;
  logic [BC_W-1:0] beat_cnt, out_cnt;
  logic [7:0] gap_cnt;
  logic [ID_W-1:0] tags [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  // Scan from the highest offset down so the requester closest to rr_ptr wins.
  always_comb begin
    found = 1'b0;
    pick = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (bus.req_valid[(int'(rr_ptr) + i) % NUM_REQ]) begin
        found = 1'b1;
        pick = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
      end
  end
  assign full = count == CNT_W'(MAX_OUTSTANDING);
  assign push = state == IDLE && found && !full;
  assign pop = bus.core_out_start && count != '0;
  assign last_beat = beat_cnt == BC_W'(FRAME_BEATS - 1);
  assign rsp_more = bus.rsp_valid && !bus.rsp_last;
  assign bus.req_ready = state == STREAM ? NUM_REQ'(1) << grant : '0;
  assign busy = state != IDLE || count != '0;
  always_comb begin
    state_nx = state;
    if (push) state_nx = STREAM;
    if (state == STREAM && last_beat) state_nx = GAP_CYCLES > 0 ? GAP : IDLE;
    if (state == GAP && gap_cnt == 8'(GAP_CYCLES - 1)) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
      grant <= '0;
      beat_cnt <= '0;
      gap_cnt <= '0;
      bus.core_in_data <= '0;
      bus.core_in_start <= '0;
      err_underrun <= 1'b0;
    end else begin
      bus.core_in_data <= '0;
      bus.core_in_start <= '0;
      if (push) begin
        grant <= pick;
        rr_ptr <= pick == ID_W'(NUM_REQ - 1) ? '0 : pick + ID_W'(1);
        beat_cnt <= '0;
      end
      // A missing beat is replaced by zeros; the frame never stalls.
      if (state == STREAM) begin
        bus.core_in_data <= bus.req_valid[grant] ? bus.req_data[int'(grant)*BEAT_W +: BEAT_W] : '0;
        bus.core_in_start <= {NUM_STAGES{beat_cnt == '0}};
        if (!bus.req_valid[grant]) err_underrun <= 1'b1;
        beat_cnt <= beat_cnt + BC_W'(1);
        gap_cnt <= '0;
      end
      if (state == GAP) gap_cnt <= gap_cnt + 8'd1;
    end
  end
  always_ff @(posedge clk)
    if (push) tags[wr_ptr] <= pick;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr == PTR_W'(MAX_OUTSTANDING - 1) ? '0 : wr_ptr + PTR_W'(1);
      if (pop) rd_ptr <= rd_ptr == PTR_W'(MAX_OUTSTANDING - 1) ? '0 : rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end
  // A new core frame always restarts the response; a frame still in progress is truncated.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_cnt <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_first <= 1'b0;
      bus.rsp_last <= 1'b0;
      bus.rsp_id <= '0;
      bus.rsp_data <= '0;
      err_spurious <= 1'b0;
      err_overlap <= 1'b0;
    end else if (bus.core_out_start) begin
      if (rsp_more) err_overlap <= 1'b1;
      if (!pop) err_spurious <= 1'b1;
      out_cnt <= '0;
      bus.rsp_valid <= pop;
      bus.rsp_first <= pop;
      bus.rsp_last <= pop && FRAME_BEATS == 1;
      bus.rsp_id <= pop ? tags[rd_ptr] : '0;
      bus.rsp_data <= pop ? bus.core_out_data : '0;
    end else begin
      out_cnt <= out_cnt + BC_W'(1);
      bus.rsp_valid <= rsp_more;
      bus.rsp_first <= 1'b0;
      bus.rsp_last <= rsp_more && out_cnt == BC_W'(FRAME_BEATS - 2);
      bus.rsp_id <= rsp_more ? bus.rsp_id : '0;
      bus.rsp_data <= rsp_more ? bus.core_out_data : '0;
    end
  end
endmodule

// File: tb/tb_ntt_frame_scheduler.sv
// tb_ntt_frame_scheduler: directed stimulus with expected frames queued and checked by independent monitors
module tb_ntt_frame_scheduler;
  localparam int DW = 28, IPC = 64, BW = DW * IPC, FB = 16, NS = 9, NR = 2;
  typedef struct {int r; int d;} fr_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  int errors = 0, checks = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  ntt_frame_scheduler_if #(.NUM_REQ(NR), .BEAT_W(BW), .NUM_STAGES(NS), .ID_W(1)) a();
  ntt_frame_scheduler_if #(.NUM_REQ(NR), .BEAT_W(8), .NUM_STAGES(NS), .ID_W(1)) b();
  logic busy, eu, es, eo, b_busy, b_eu, b_es, b_eo;
  ntt_frame_scheduler dut (.clk(clk), .rst(rst), .bus(a.slave), .busy(busy),
    .err_underrun(eu), .err_spurious(es), .err_overlap(eo));
  ntt_frame_scheduler #(.DATA_WIDTH_PER_INPUT(4), .INPUT_PER_CYCLE(2), .GAP_CYCLES(3)) dut_gap (
    .clk(clk), .rst(rst), .bus(b.slave), .busy(b_busy),
    .err_underrun(b_eu), .err_spurious(b_es), .err_overlap(b_eo));
  function automatic logic [BW-1:0] beat(logic [27:0] v);
    return {IPC{v}};
  endfunction
  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  task automatic chkw(string n, logic [BW-1:0] act, logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", n, act[63:0], exp[63:0], cyc);
    end
  endtask
  // requester model: beat index advances whenever the DUT offers ready
  int issued[NR] = '{0, 0};
  int done[NR] = '{0, 0};
  int bk[NR] = '{0, 0};
  int drop[NR] = '{-1, -1};
  always_comb
    for (int r = 0; r < NR; r++) begin
      a.req_valid[r] = issued[r] > done[r] && bk[r] != drop[r];
      a.req_data[r*BW +: BW] = beat(28'(r * 256 + bk[r]));
    end
  always @(posedge clk)
    for (int r = 0; r < NR; r++)
      if (!rst) begin
        done[r] <= issued[r];
        bk[r] <= 0;
      end else if (a.req_ready[r]) begin
        bk[r] <= bk[r] == FB - 1 ? 0 : bk[r] + 1;
        if (bk[r] == FB - 1) done[r] <= done[r] + 1;
      end
  fr_t exp_in[$];
  int exp_rsp[$];
  int starts[$];
  int bst[$];
  int bdat[$];
  int rdy0 = 0;
  always @(negedge clk) if (a.req_ready[0]) rdy0++;
  // core input monitor
  fr_t cur;
  int ik = -1;
  always @(negedge clk) begin
    if (!rst) ik = -1;
    else begin
      if (a.core_in_start != '0) begin
        chk("start all-ones", a.core_in_start, 9'h1ff);
        chk("start outside frame", ik, -1);
        if (exp_in.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL unexpected start: got start want none (cycle %0d)", cyc);
          cur = '{0, -1};
        end else cur = exp_in.pop_front();
        starts.push_back(cyc);
        ik = 0;
      end
      if (ik >= 0) begin
        chkw("core_in beat", a.core_in_data, ik == cur.d ? '0 : beat(28'(cur.r * 256 + ik)));
        ik = ik == FB - 1 ? -1 : ik + 1;
      end else chkw("core_in idle", a.core_in_data, '0);
    end
  end
  // response monitor
  int rk = -1, rid = 0;
  always @(negedge clk) begin
    if (!rst) rk = -1;
    else if (a.rsp_valid) begin
      if (a.rsp_first) begin
        if (exp_rsp.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL unexpected rsp frame: got id %0d want none (cycle %0d)", a.rsp_id, cyc);
          rid = 0;
        end else begin
          rid = exp_rsp.pop_front();
          chk("rsp_id", a.rsp_id, rid);
        end
        rk = 0;
      end
      chk("rsp beat after first", rk >= 0, 1);
      chkw("rsp_data", a.rsp_data, beat(28'(32768 + rid * 256 + rk)));
      chk("rsp_last", a.rsp_last, rk == FB - 1);
      rk = (rk == FB - 1 || rk < 0) ? -1 : rk + 1;
    end
  end
  always @(negedge clk)
    if (rst && b.core_in_start != '0) begin
      bst.push_back(cyc);
      bdat.push_back(int'(b.core_in_data));
    end
  task automatic expect_in(int r, int d);
    fr_t f;
    f.r = r;
    f.d = d;
    exp_in.push_back(f);
  endtask
  task automatic drive_out(int id, int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      a.core_out_start = k == 0;
      a.core_out_data = beat(28'(32768 + id * 256 + k));
    end
  endtask
  task automatic idle_out();
    @(negedge clk);
    a.core_out_start = 1'b0;
    a.core_out_data = '0;
  endtask
  task automatic wait_in();
    for (int i = 0; i < 400 && (exp_in.size() != 0 || ik != -1); i++) @(negedge clk);
    chk("input frames drained", exp_in.size() != 0 || ik != -1, 0);
  endtask
  task automatic wait_out();
    for (int i = 0; i < 400 && (exp_rsp.size() != 0 || rk != -1); i++) @(negedge clk);
    chk("response frames drained", exp_rsp.size() != 0 || rk != -1, 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  initial begin
    int base, r0;
    a.core_out_start = 1'b0;
    a.core_out_data = '0;
    b.req_valid = '0;
    b.req_data = 16'h2211;
    b.core_out_start = 1'b0;
    b.core_out_data = '0;
    repeat (3) @(negedge clk);
    chk("reset core_in_start", a.core_in_start, 0);
    chkw("reset core_in_data", a.core_in_data, '0);
    chk("reset req_ready", a.req_ready, 0);
    chk("reset rsp_valid", a.rsp_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset errors", {eu, es, eo}, 0);
    rst = 1'b1;
    b.req_valid = 2'b11;
    // single frame from requester 0
    @(negedge clk);
    r0 = rdy0;
    expect_in(0, -1);
    issued[0]++;
    wait_in();
    chk("t1 ready cycles", rdy0 - r0, 16);
    chk("t1 start count", starts.size(), 1);
    exp_rsp.push_back(0);
    drive_out(0, 16);
    idle_out();
    wait_out();
    chk("t1 idle busy", busy, 0);
    // both requesters, rr pointer now at 1; fifth frame must block on a full tag FIFO
    base = starts.size();
    expect_in(1, -1);
    expect_in(0, -1);
    expect_in(1, -1);
    expect_in(0, -1);
    expect_in(0, -1);
    issued[0] += 3;
    issued[1] += 2;
    for (int i = 0; i < 200 && starts.size() < base + 4; i++) @(negedge clk);
    repeat (30) @(negedge clk);
    chk("full fifo start count", starts.size(), base + 4);
    for (int j = base + 1; j < starts.size() && j < base + 4; j++)
      chk("start spacing gap0", starts[j] - starts[j-1], 17);
    chk("full fifo busy", busy, 1);
    chk("full fifo no grant", a.req_ready, 0);
    exp_rsp.push_back(1);
    fork
      drive_out(1, 16);
      begin
        @(negedge clk);
        @(negedge clk);
        chk("ready before regrant", a.req_ready, 0);
        @(negedge clk);
        chk("regrant after pop", a.req_ready, 1);
      end
    join
    exp_rsp.push_back(0);
    exp_rsp.push_back(1);
    exp_rsp.push_back(0);
    exp_rsp.push_back(0);
    drive_out(0, 16);
    drive_out(1, 16);
    drive_out(0, 16);
    drive_out(0, 16);
    idle_out();
    wait_in();
    wait_out();
    chk("no overlap back-to-back", eo, 0);
    chk("no underrun yet", eu, 0);
    chk("drained busy", busy, 0);
    // underrun on beat 5, then a spurious core frame
    drop[1] = 5;
    expect_in(1, 5);
    issued[1]++;
    wait_in();
    drop[1] = -1;
    chk("underrun flag", eu, 1);
    exp_rsp.push_back(1);
    drive_out(1, 16);
    idle_out();
    wait_out();
    chk("no spurious yet", es, 0);
    drive_out(0, 1);
    idle_out();
    repeat (20) @(negedge clk);
    chk("spurious flag", es, 1);
    chk("spurious busy", busy, 0);
    // overlapping core frames: first truncated after 5 beats
    expect_in(0, -1);
    expect_in(0, -1);
    issued[0] += 2;
    wait_in();
    exp_rsp.push_back(0);
    exp_rsp.push_back(0);
    drive_out(0, 5);
    drive_out(0, 16);
    idle_out();
    wait_out();
    chk("overlap flag", eo, 1);
    // gap instance: alternating grants spaced 20 cycles, four frames then full
    chk("gap starts", bst.size(), 4);
    for (int j = 1; j < bst.size(); j++) chk("start spacing gap3", bst[j] - bst[j-1], 20);
    for (int j = 0; j < bst.size(); j++) chk("gap grant order", bdat[j], j % 2 ? 'h22 : 'h11);
    // reset in the middle of a stream
    expect_in(0, -1);
    issued[0]++;
    for (int i = 0; i < 100 && bk[0] != 8; i++) @(negedge clk);
    chk("reached beat 8", bk[0], 8);
    #1 rst = 1'b0;
    #1;
    chkw("mid reset core_in_data", a.core_in_data, '0);
    chk("mid reset core_in_start", a.core_in_start, 0);
    chk("mid reset req_ready", a.req_ready, 0);
    chk("mid reset rsp_valid", a.rsp_valid, 0);
    chk("mid reset busy", busy, 0);
    chk("mid reset errors", {eu, es, eo}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    expect_in(1, -1);
    issued[1]++;
    wait_in();
    exp_rsp.push_back(1);
    drive_out(1, 16);
    idle_out();
    wait_out();
    chk("post reset busy", busy, 0);
    chk("post reset errors", {eu, es, eo}, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
